// File: rtl/if_id_skid_stage.sv
// rtl/if_id_skid_stage.sv - fetch-to-decode stage register with one-entry skid buffer
module if_id_skid_stage #(
   parameter int INSTR_W = 16,
   parameter int PC_W    = 16
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               IN_VALID,
   input  logic [PC_W-1:0]    IN_PC,
   input  logic [INSTR_W-1:0] IN_INSTR,
   output logic               IN_READY,
   output logic               OUT_VALID,
   output logic [PC_W-1:0]    OUT_PC,
   output logic [INSTR_W-1:0] OUT_INSTR,
   input  logic               OUT_READY,
   input  logic               FLUSH,
   output logic [1:0]         OCCUPANCY
);

   logic               main_valid_q, main_valid_d;
   logic [PC_W-1:0]    main_pc_q, main_pc_d;
   logic [INSTR_W-1:0] main_instr_q, main_instr_d;
   logic               skid_valid_q, skid_valid_d;
   logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
   logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
   logic               in_ready_q, in_ready_d;
   logic [1:0]         occupancy_q, occupancy_d;

   logic accept;
   logic pop;
   logic main_from_in;
   logic main_from_skid;
   logic skid_from_in;

   assign accept = IN_VALID & in_ready_q;
   assign pop    = main_valid_q & OUT_READY;

   // Valid bookkeeping and write enables; payloads only move when an enable fires.
   always_comb begin
      main_valid_d   = main_valid_q;
      skid_valid_d   = skid_valid_q;
      main_from_in   = 1'b0;
      main_from_skid = 1'b0;
      skid_from_in   = 1'b0;

      if (FLUSH) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!main_valid_q) begin
         if (accept) begin
            main_from_in = 1'b1;
            main_valid_d = 1'b1;
         end
      end else if (pop) begin
         if (skid_valid_q) begin
            main_from_skid = 1'b1;
            if (accept) begin
               skid_from_in = 1'b1;
            end else begin
               skid_valid_d = 1'b0;
            end
         end else if (accept) begin
            main_from_in = 1'b1;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_from_in = 1'b1;
         skid_valid_d = 1'b1;
      end
   end

   always_comb begin
      main_pc_d    = main_pc_q;
      main_instr_d = main_instr_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;

      if (main_from_skid) begin
         main_pc_d    = skid_pc_q;
         main_instr_d = skid_instr_q;
      end else if (main_from_in) begin
         main_pc_d    = IN_PC;
         main_instr_d = IN_INSTR;
      end

      if (skid_from_in) begin
         skid_pc_d    = IN_PC;
         skid_instr_d = IN_INSTR;
      end
   end

   // Ready is registered from the next skid state so OUT_READY never reaches IN_READY combinationally.
   always_comb begin
      in_ready_d  = ~skid_valid_d;
      occupancy_d = {1'b0, main_valid_d} + {1'b0, skid_valid_d};
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
         occupancy_q  <= 2'd0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
         occupancy_q  <= occupancy_d;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         main_pc_q    <= '0;
         main_instr_q <= '0;
         skid_pc_q    <= '0;
         skid_instr_q <= '0;
      end else begin
         main_pc_q    <= main_pc_d;
         main_instr_q <= main_instr_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
      end
   end

   assign IN_READY  = in_ready_q;
   assign OUT_VALID = main_valid_q;
   assign OUT_PC    = main_pc_q;
   assign OUT_INSTR = main_instr_q;
   assign OCCUPANCY = occupancy_q;

endmodule

// File: tb/tb_if_id_skid_stage.sv
// tb/tb_if_id_skid_stage.sv - scoreboard bench for if_id_skid_stage
module tb_if_id_skid_stage;

   logic        CLK = 1'b0;
   logic        RST;
   logic        IN_VALID;
   logic [15:0] IN_PC;
   logic [15:0] IN_INSTR;
   logic        IN_READY;
   logic        OUT_VALID;
   logic [15:0] OUT_PC;
   logic [15:0] OUT_INSTR;
   logic        OUT_READY;
   logic        FLUSH;
   logic [1:0]  OCCUPANCY;

   if_id_skid_stage #(.INSTR_W(16), .PC_W(16)) dut (
      .CLK(CLK), .RST(RST),
      .IN_VALID(IN_VALID), .IN_PC(IN_PC), .IN_INSTR(IN_INSTR), .IN_READY(IN_READY),
      .OUT_VALID(OUT_VALID), .OUT_PC(OUT_PC), .OUT_INSTR(OUT_INSTR), .OUT_READY(OUT_READY),
      .FLUSH(FLUSH), .OCCUPANCY(OCCUPANCY)
   );

   always #5 CLK = ~CLK;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] sb[$];
   int          held_n   = 0;
   bit          moved_on = 1'b1;
   bit          beef_seen = 1'b0;
   bit          m_acc;
   bit          m_pop;
   logic [15:0] pc_ctr = 16'h1000;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
   endtask

   task automatic step(input logic iv, input logic [15:0] pc, input logic [15:0] instr,
                       input logic ordy, input logic fl);
      @(posedge CLK);
      #2;
      IN_VALID  = iv;
      IN_PC     = pc;
      IN_INSTR  = instr;
      OUT_READY = ordy;
      FLUSH     = fl;
   endtask

   // Reference model: a count of held entries and a FIFO of accepted payloads.
   initial forever begin
      @(posedge CLK or posedge RST);
      if (RST) begin
         sb.delete();
         held_n   = 0;
         moved_on = 1'b1;
      end else begin
         m_acc    = IN_VALID && (held_n < 2);
         m_pop    = (held_n > 0) && OUT_READY;
         moved_on = m_acc || FLUSH;
         if (FLUSH) begin
            sb.delete();
            held_n = 0;
         end else begin
            if (m_acc) sb.push_back({IN_PC, IN_INSTR});
            held_n = held_n - int'(m_pop) + int'(m_acc);
         end
      end
   end

   // Monitor: compares stage status every cycle and retires the scoreboard head on each pop.
   initial forever begin
      @(negedge CLK);
      if (!RST) begin
         check("occupancy", 32'(OCCUPANCY), 32'(held_n));
         check("in_ready", 32'(IN_READY), 32'(held_n < 2));
         check("out_valid", 32'(OUT_VALID), 32'(held_n > 0));
         check("skid_implies_main", 32'(dut.skid_valid_q & ~dut.main_valid_q), 32'd0);
         if (OUT_VALID && OUT_INSTR == 16'hBEEF) beef_seen = 1'b1;
         if (OUT_VALID && sb.size() > 0) begin
            check("out_payload", {OUT_PC, OUT_INSTR}, sb[0]);
            if (OUT_READY && !FLUSH) void'(sb.pop_front());
         end
      end
   end

   initial begin
      RST = 1'b1; IN_VALID = 1'b0; IN_PC = '0; IN_INSTR = '0; OUT_READY = 1'b0; FLUSH = 1'b0;
      repeat (2) @(negedge CLK);
      check("rst_out_valid", 32'(OUT_VALID), 32'd0);
      check("rst_out_pc", 32'(OUT_PC), 32'd0);
      check("rst_out_instr", 32'(OUT_INSTR), 32'd0);
      check("rst_in_ready", 32'(IN_READY), 32'd1);
      check("rst_occupancy", 32'(OCCUPANCY), 32'd0);
      RST = 1'b0;

      // Single instruction latency
      step(1'b1, 16'h0000, 16'h1234, 1'b1, 1'b0);
      step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
      @(negedge CLK);
      check("t1_out_valid", 32'(OUT_VALID), 32'd1);
      check("t1_out_pc", 32'(OUT_PC), 32'h0000);
      check("t1_out_instr", 32'(OUT_INSTR), 32'h1234);
      check("t1_occupancy", 32'(OCCUPANCY), 32'd1);

      // Streaming at full rate
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 16'(i), 16'h2000 + 16'(i), 1'b1, 1'b0);
         @(negedge CLK);
         check("t2_in_ready", 32'(IN_READY), 32'd1);
         check("t2_occ_le1", 32'(OCCUPANCY <= 2'd1), 32'd1);
      end
      step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
      step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);

      // Stall fills the skid; third instruction is held off by fetch
      step(1'b1, 16'h0010, 16'hA001, 1'b0, 1'b0);
      step(1'b1, 16'h0011, 16'hA002, 1'b0, 1'b0);
      step(1'b1, 16'h0012, 16'hA003, 1'b0, 1'b0);
      @(negedge CLK);
      check("t3_in_ready_low", 32'(IN_READY), 32'd0);
      check("t3_occ_full", 32'(OCCUPANCY), 32'd2);
      check("t3_head", 32'(OUT_INSTR), 32'hA001);
      step(1'b1, 16'h0012, 16'hA003, 1'b1, 1'b0);
      step(1'b1, 16'h0012, 16'hA003, 1'b1, 1'b0);
      @(negedge CLK);
      check("t3_in_ready_back", 32'(IN_READY), 32'd1);
      check("t3_second", 32'(OUT_INSTR), 32'hA002);
      step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
      @(negedge CLK);
      check("t3_third", 32'(OUT_INSTR), 32'hA003);
      step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);

      // Flush with both entries full and a new instruction presented
      beef_seen = 1'b0;
      step(1'b1, 16'h0020, 16'hB001, 1'b0, 1'b0);
      step(1'b1, 16'h0021, 16'hB002, 1'b0, 1'b0);
      step(1'b1, 16'h0022, 16'hBEEF, 1'b0, 1'b1);
      step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
      @(negedge CLK);
      check("t4_out_valid", 32'(OUT_VALID), 32'd0);
      check("t4_occupancy", 32'(OCCUPANCY), 32'd0);
      check("t4_in_ready", 32'(IN_READY), 32'd1);
      repeat (3) step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
      @(negedge CLK);
      check("t4_beef_never_out", 32'(beef_seen), 32'd0);

      // Asynchronous reset while full
      step(1'b1, 16'h0030, 16'hC001, 1'b0, 1'b0);
      step(1'b1, 16'h0031, 16'hC002, 1'b0, 1'b0);
      step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      @(negedge CLK);
      check("t5_pre_occ", 32'(OCCUPANCY), 32'd2);
      #2 RST = 1'b1;
      #1;
      check("t5_out_valid", 32'(OUT_VALID), 32'd0);
      check("t5_out_pc", 32'(OUT_PC), 32'd0);
      check("t5_out_instr", 32'(OUT_INSTR), 32'd0);
      check("t5_in_ready", 32'(IN_READY), 32'd1);
      check("t5_occupancy", 32'(OCCUPANCY), 32'd0);
      @(negedge CLK);
      RST = 1'b0;
      step(1'b1, 16'h0040, 16'hD001, 1'b1, 1'b0);
      step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
      @(negedge CLK);
      check("t5_after_valid", 32'(OUT_VALID), 32'd1);
      check("t5_after_pc", 32'(OUT_PC), 32'h0040);
      check("t5_after_instr", 32'(OUT_INSTR), 32'hD001);

      // Random traffic; fetch holds an unaccepted instruction until taken or flushed
      for (int c = 0; c < 10000; c++) begin
         logic        iv;
         logic [15:0] pc;
         logic [15:0] instr;
         @(posedge CLK);
         #2;
         if (IN_VALID && !moved_on) begin
            iv = 1'b1; pc = IN_PC; instr = IN_INSTR;
         end else begin
            iv = ($urandom_range(0, 9) < 7);
            pc = pc_ctr;
            instr = 16'($urandom);
            if (iv) pc_ctr = pc_ctr + 16'd1;
         end
         IN_VALID  = iv;
         IN_PC     = pc;
         IN_INSTR  = instr;
         OUT_READY = ($urandom_range(0, 9) < 6);
         FLUSH     = ($urandom_range(0, 99) < 3);
      end
      repeat (4) step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
      @(negedge CLK);
      check("drain_empty", 32'(OCCUPANCY), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
